mem_wb_stage: RTL and testbench

Memory-to-writeback pipeline stage of the Mini-RISC-V core. It captures each EX/MEM instruction and waits for load data from the data-memory port, stalling the pipeline through `mem_hold` while it waits. It aligns and sign- or zero-extends load data, then drives the registered `MEM_WB_rd`, `MEM_WB_regwrite` and `WB_res` signals that feed the register-file write port.

---
 rtl/mem_wb_stage_if.sv | 30 +++
 rtl/mem_wb_stage.sv | 157 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB stage bundle: EX/MEM instruction fields, data-memory read
// return, and the registered writeback outputs with stall/error status.
interface mem_wb_stage_if;
   logic        EX_MEM_valid;
   logic        EX_MEM_regwrite;
   logic        EX_MEM_memread;
   logic [4:0]  EX_MEM_rd;
   logic [2:0]  EX_MEM_funct3;
   logic [31:0] EX_MEM_alures;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic [4:0]  MEM_WB_rd;
   logic        MEM_WB_regwrite;
   logic [31:0] WB_res;
   logic        mem_hold;
   logic        load_err;
   logic        bus_err;

   modport master (
      output EX_MEM_valid, EX_MEM_regwrite, EX_MEM_memread, EX_MEM_rd,
             EX_MEM_funct3, EX_MEM_alures, mem_rdata, mem_rvalid,
      input  MEM_WB_rd, MEM_WB_regwrite, WB_res, mem_hold, load_err, bus_err
   );

   modport slave (
      input  EX_MEM_valid, EX_MEM_regwrite, EX_MEM_memread, EX_MEM_rd,
             EX_MEM_funct3, EX_MEM_alures, mem_rdata, mem_rvalid,
      output MEM_WB_rd, MEM_WB_regwrite, WB_res, mem_hold, load_err, bus_err
   );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-to-writeback stage: waits for load data (stalling upstream via
// mem_hold), aligns/extends it, and registers the register-file write port.
module mem_wb_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input logic           clk,
   input logic           Rst_n,
   mem_wb_stage_if.slave bus
);

   typedef enum logic {IDLE, LOAD_WAIT} state_t;

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   state_t      state, state_next;
   logic [7:0]  cnt, cnt_next;
   logic [4:0]  l_rd;
   logic        l_regwrite;
   logic [2:0]  l_funct3;
   logic [1:0]  l_off;

   logic        ld, done, timeout_hit, hold;
   logic [4:0]  cur_rd;
   logic        cur_regwrite;
   logic [2:0]  cur_funct3;
   logic [1:0]  cur_off;
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic [31:0] ld_val;
   logic        ld_fault;

   logic [4:0]  wb_rd;
   logic        wb_regwrite;
   logic [31:0] wb_res;
   logic        load_err_q, bus_err_q;

   assign ld          = bus.EX_MEM_valid & bus.EX_MEM_memread;
   assign done        = (state == IDLE & ld & bus.mem_rvalid) |
                        (state == LOAD_WAIT & bus.mem_rvalid);
   assign timeout_hit = (state == LOAD_WAIT) & ~bus.mem_rvalid & (cnt == LAST);
   // Gated by reset so the stall releases the instant reset is asserted.
   assign hold        = Rst_n & ((state == IDLE & ld & ~bus.mem_rvalid) |
                        (state == LOAD_WAIT & ~bus.mem_rvalid & cnt != LAST));

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      cur_rd       = l_rd;
      cur_regwrite = l_regwrite;
      cur_funct3   = l_funct3;
      cur_off      = l_off;
      if (state == IDLE) begin
         cur_rd       = bus.EX_MEM_rd;
         cur_regwrite = bus.EX_MEM_regwrite;
         cur_funct3   = bus.EX_MEM_funct3;
         cur_off      = bus.EX_MEM_alures[1:0];
      end
   end

   always_comb begin
      byte_val = bus.mem_rdata[8*cur_off +: 8];
      half_val = cur_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      ld_val   = bus.mem_rdata;
      ld_fault = 1'b0;
      case (cur_funct3)
         3'b000:  ld_val = {{24{byte_val[7]}}, byte_val};
         3'b001: begin
            ld_val   = {{16{half_val[15]}}, half_val};
            ld_fault = cur_off[0];
         end
         3'b010:  ld_fault = (cur_off != 2'b00);
         3'b100:  ld_val = {24'd0, byte_val};
         3'b101: begin
            ld_val   = {16'd0, half_val};
            ld_fault = cur_off[0];
         end
         default: ld_fault = 1'b1;
      endcase
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: if (ld && !bus.mem_rvalid) begin
            state_next = LOAD_WAIT;
            cnt_next   = 8'd0;
         end
         LOAD_WAIT: begin
            if (bus.mem_rvalid || timeout_hit) state_next = IDLE;
            else                               cnt_next   = cnt + 8'd1;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         l_rd       <= 5'd0;
         l_regwrite <= 1'b0;
         l_funct3   <= 3'd0;
         l_off      <= 2'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (state == IDLE && ld && !bus.mem_rvalid) begin
            l_rd       <= bus.EX_MEM_rd;
            l_regwrite <= bus.EX_MEM_regwrite;
            l_funct3   <= bus.EX_MEM_funct3;
            l_off      <= bus.EX_MEM_alures[1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wb_rd       <= 5'd0;
         wb_regwrite <= 1'b0;
         wb_res      <= 32'd0;
         load_err_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         load_err_q <= 1'b0;
         if (!hold) begin
            if (timeout_hit) begin
               wb_regwrite <= 1'b0;
               bus_err_q   <= 1'b1;
            end else if (done) begin
               if (ld_fault) begin
                  wb_regwrite <= 1'b0;
                  load_err_q  <= 1'b1;
               end else begin
                  wb_rd       <= cur_rd;
                  wb_regwrite <= cur_regwrite;
                  wb_res      <= ld_val;
               end
            end else if (state == IDLE && bus.EX_MEM_valid) begin
               wb_rd       <= bus.EX_MEM_rd;
               wb_regwrite <= bus.EX_MEM_regwrite;
               wb_res      <= bus.EX_MEM_alures;
            end else begin
               wb_regwrite <= 1'b0;
            end
         end
      end
   end

   assign bus.MEM_WB_rd       = wb_rd;
   assign bus.MEM_WB_regwrite = wb_regwrite;
   assign bus.WB_res          = wb_res;
   assign bus.mem_hold        = hold;
   assign bus.load_err        = load_err_q;
   assign bus.bus_err         = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: each task drives one scenario and checks
// outputs against hand-computed values.
module tb_mem_wb_stage;

   logic clk = 1'b0;
   logic Rst_n;
   int   checks = 0;
   int   errors = 0;

   mem_wb_stage_if bus ();

   mem_wb_stage #(.TIMEOUT(16)) dut (
      .clk   (clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.EX_MEM_valid    = 1'b0;
      bus.EX_MEM_regwrite = 1'b0;
      bus.EX_MEM_memread  = 1'b0;
      bus.EX_MEM_rd       = 5'd0;
      bus.EX_MEM_funct3   = 3'd0;
      bus.EX_MEM_alures   = 32'd0;
      bus.mem_rdata       = 32'd0;
      bus.mem_rvalid      = 1'b0;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
      drive_idle();
      bus.EX_MEM_valid    = 1'b1;
      bus.EX_MEM_regwrite = 1'b1;
      bus.EX_MEM_rd       = rd;
      bus.EX_MEM_alures   = res;
   endtask

   task automatic drive_load(input logic [2:0] f3, input logic [4:0] rd,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic rvalid);
      drive_idle();
      bus.EX_MEM_valid    = 1'b1;
      bus.EX_MEM_regwrite = 1'b1;
      bus.EX_MEM_memread  = 1'b1;
      bus.EX_MEM_rd       = rd;
      bus.EX_MEM_funct3   = f3;
      bus.EX_MEM_alures   = addr;
      bus.mem_rdata       = data;
      bus.mem_rvalid      = rvalid;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      drive_load(3'b010, 5'd1, 32'h0, 32'h0, 1'b0);
      #12;
      checks++; if (bus.mem_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", bus.mem_hold); end
      checks++; if ({bus.MEM_WB_rd, bus.MEM_WB_regwrite, bus.WB_res, bus.load_err, bus.bus_err} !== 40'd0) begin
         errors++; $display("FAIL reset_outputs got rd=%0d we=%b res=%h lerr=%b berr=%b want all 0",
                             bus.MEM_WB_rd, bus.MEM_WB_regwrite, bus.WB_res, bus.load_err, bus.bus_err);
      end
      drive_idle();
      #2 Rst_n = 1'b1;
      tick();
   endtask

   task automatic test_alu();
      drive_alu(5'd5, 32'h1234_5678);
      #1;
      checks++; if (bus.mem_hold !== 1'b0) begin errors++; $display("FAIL alu_hold got %b want 0", bus.mem_hold); end
      tick();
      drive_idle();
      checks++; if (bus.MEM_WB_rd !== 5'd5 || bus.MEM_WB_regwrite !== 1'b1 || bus.WB_res !== 32'h1234_5678) begin
         errors++; $display("FAIL alu_result got rd=%0d we=%b res=%h want rd=5 we=1 res=12345678",
                             bus.MEM_WB_rd, bus.MEM_WB_regwrite, bus.WB_res);
      end
      tick();
      checks++; if (bus.MEM_WB_regwrite !== 1'b0 || bus.MEM_WB_rd !== 5'd5 || bus.WB_res !== 32'h1234_5678) begin
         errors++; $display("FAIL bubble got rd=%0d we=%b res=%h want rd=5 we=0 res=12345678",
                             bus.MEM_WB_rd, bus.MEM_WB_regwrite, bus.WB_res);
      end
   endtask

   task automatic test_lb_stall();
      int hold_cnt = 0;
      drive_alu(5'd9, 32'hA5A5_A5A5);
      tick();
      drive_load(3'b000, 5'd7, 32'h0000_1003, 32'h80FF_0000, 1'b0);
      for (int k = 0; k < 4; k++) begin
         bus.mem_rvalid = (k == 3);
         #1;
         if (bus.mem_hold) hold_cnt++;
         checks++; if (bus.MEM_WB_rd !== 5'd9 || bus.WB_res !== 32'hA5A5_A5A5 || bus.MEM_WB_regwrite !== 1'b1) begin
            errors++; $display("FAIL lb_older_held k=%0d got rd=%0d res=%h we=%b want rd=9 res=a5a5a5a5 we=1",
                                k, bus.MEM_WB_rd, bus.WB_res, bus.MEM_WB_regwrite);
         end
         tick();
      end
      drive_idle();
      checks++; if (hold_cnt !== 3) begin errors++; $display("FAIL lb_hold_cycles got %0d want 3", hold_cnt); end
      checks++; if (bus.MEM_WB_rd !== 5'd7 || bus.MEM_WB_regwrite !== 1'b1 || bus.WB_res !== 32'hFFFF_FF80) begin
         errors++; $display("FAIL lb_result got rd=%0d we=%b res=%h want rd=7 we=1 res=ffffff80",
                             bus.MEM_WB_rd, bus.MEM_WB_regwrite, bus.WB_res);
      end
   endtask

   task automatic test_extend();
      logic [2:0]  f3   [5] = '{3'b101, 3'b001, 3'b100, 3'b000, 3'b010};
      logic [31:0] addr [5] = '{32'h2002, 32'h2002, 32'h3001, 32'h3001, 32'h4000};
      logic [31:0] data [5] = '{32'hBEEF_0001, 32'hBEEF_0001, 32'h0000_8000, 32'h0000_8000, 32'hDEAD_BEEF};
      logic [31:0] want [5] = '{32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0000_0080, 32'hFFFF_FF80, 32'hDEAD_BEEF};
      for (int i = 0; i < 5; i++) begin
         drive_load(f3[i], 5'(i + 10), addr[i], data[i], 1'b1);
         tick();
         drive_idle();
         checks++; if (bus.WB_res !== want[i] || bus.MEM_WB_rd !== 5'(i + 10) || bus.MEM_WB_regwrite !== 1'b1) begin
            errors++; $display("FAIL extend_%0d got rd=%0d we=%b res=%h want rd=%0d we=1 res=%h",
                                i, bus.MEM_WB_rd, bus.MEM_WB_regwrite, bus.WB_res, i + 10, want[i]);
         end
      end
   endtask

   task automatic test_load_err();
      logic [2:0]  f3   [3] = '{3'b010, 3'b011, 3'b001};
      logic [31:0] addr [3] = '{32'h2001, 32'h2000, 32'h2003};
      drive_alu(5'd4, 32'h0000_0011);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive_load(f3[i], 5'd20, addr[i], 32'h1111_2222, 1'b1);
         tick();
         drive_idle();
         checks++; if (bus.load_err !== 1'b1 || bus.MEM_WB_regwrite !== 1'b0 || bus.MEM_WB_rd !== 5'd4 || bus.WB_res !== 32'h11) begin
            errors++; $display("FAIL lerr_pulse_%0d got lerr=%b we=%b rd=%0d res=%h want lerr=1 we=0 rd=4 res=11",
                                i, bus.load_err, bus.MEM_WB_regwrite, bus.MEM_WB_rd, bus.WB_res);
         end
         tick();
         checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL lerr_width_%0d got %b want 0", i, bus.load_err); end
      end
   endtask

   task automatic test_timeout();
      int hold_cnt = 0;
      drive_load(3'b000, 5'd3, 32'h5000, 32'h0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!bus.mem_hold) break;
         hold_cnt++;
         tick();
      end
      tick();
      drive_idle();
      checks++; if (hold_cnt !== 16) begin errors++; $display("FAIL to_hold_cycles got %0d want 16", hold_cnt); end
      checks++; if (bus.bus_err !== 1'b1 || bus.MEM_WB_regwrite !== 1'b0 || bus.load_err !== 1'b0) begin
         errors++; $display("FAIL to_abort got berr=%b we=%b lerr=%b want berr=1 we=0 lerr=0",
                             bus.bus_err, bus.MEM_WB_regwrite, bus.load_err);
      end
      drive_alu(5'd6, 32'h0000_600D);
      tick();
      drive_idle();
      checks++; if (bus.MEM_WB_rd !== 5'd6 || bus.MEM_WB_regwrite !== 1'b1 || bus.WB_res !== 32'h600D || bus.bus_err !== 1'b1) begin
         errors++; $display("FAIL to_after got rd=%0d we=%b res=%h berr=%b want rd=6 we=1 res=600d berr=1",
                             bus.MEM_WB_rd, bus.MEM_WB_regwrite, bus.WB_res, bus.bus_err);
      end
   endtask

   task automatic test_reset_in_wait();
      drive_load(3'b010, 5'd8, 32'h3000, 32'h0, 1'b0);
      tick();
      #1;
      checks++; if (bus.mem_hold !== 1'b1) begin errors++; $display("FAIL rw_hold_before got %b want 1", bus.mem_hold); end
      Rst_n = 1'b0;
      #1;
      checks++; if (bus.mem_hold !== 1'b0) begin errors++; $display("FAIL rw_hold_drop got %b want 0", bus.mem_hold); end
      checks++; if ({bus.MEM_WB_rd, bus.MEM_WB_regwrite, bus.WB_res, bus.load_err, bus.bus_err} !== 40'd0) begin
         errors++; $display("FAIL rw_outputs got rd=%0d we=%b res=%h lerr=%b berr=%b want all 0",
                             bus.MEM_WB_rd, bus.MEM_WB_regwrite, bus.WB_res, bus.load_err, bus.bus_err);
      end
      drive_idle();
      #3 Rst_n = 1'b1;
      tick();
      drive_load(3'b010, 5'd8, 32'h3000, 32'hCAFE_F00D, 1'b1);
      #1;
      checks++; if (bus.mem_hold !== 1'b0) begin errors++; $display("FAIL rw_new_hold got %b want 0", bus.mem_hold); end
      tick();
      drive_idle();
      checks++; if (bus.MEM_WB_rd !== 5'd8 || bus.MEM_WB_regwrite !== 1'b1 || bus.WB_res !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL rw_new_load got rd=%0d we=%b res=%h want rd=8 we=1 res=cafef00d",
                             bus.MEM_WB_rd, bus.MEM_WB_regwrite, bus.WB_res);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  f3   [3] = '{3'b000, 3'b100, 3'b101};
      logic [31:0] addr [3] = '{32'h6000, 32'h6003, 32'h6000};
      logic [31:0] data [3] = '{32'h0000_007F, 32'hF100_0000, 32'h1234_8001};
      logic [31:0] want [3] = '{32'h0000_007F, 32'h0000_00F1, 32'h0000_8001};
      for (int i = 0; i < 3; i++) begin
         drive_load(f3[i], 5'(i + 1), addr[i], data[i], 1'b1);
         #1;
         checks++; if (bus.mem_hold !== 1'b0) begin errors++; $display("FAIL b2b_hold_%0d got %b want 0", i, bus.mem_hold); end
         tick();
         checks++; if (bus.WB_res !== want[i] || bus.MEM_WB_rd !== 5'(i + 1) || bus.MEM_WB_regwrite !== 1'b1) begin
            errors++; $display("FAIL b2b_res_%0d got rd=%0d we=%b res=%h want rd=%0d we=1 res=%h",
                                i, bus.MEM_WB_rd, bus.MEM_WB_regwrite, bus.WB_res, i + 1, want[i]);
         end
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_lb_stall();
      test_extend();
      test_load_err();
      test_timeout();
      test_reset_in_wait();
      test_back_to_back();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
